// File: rtl/mem_image_loader_if.sv
// Byte-stream and RAM-write bundle for the image loader.
//   byte_data/byte_valid/byte_ready : incoming byte stream (valid/ready)
//   mem_we/mem_addr/mem_wdata       : word write port into CPU RAM
// master = loader side, slave = stream source / RAM side.
interface mem_image_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_image_loader.sv
// Data-memory image loader: packs a byte stream into 32-bit words, writes them
// sequentially into CPU RAM from BASE_WORD, and holds the CPU in reset until
// WORD_COUNT words have been committed.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : one-cycle pulse, starts a load from IDLE or DONE
//   bus            : byte stream in + RAM write port out (master modport)
//   cpu_rst_n      : CPU reset, high only in DONE
//   busy / done    : load in progress / image complete
//   words_written  : words committed in this load
//   checksum       : sum mod 2^32 of words committed in this load
//
// state | meaning
// IDLE  | after reset, CPU held in reset, waiting for start
// RECV  | accepting bytes into the pack register
// WRITE | one-cycle RAM write of the packed word
// DONE  | image complete, CPU released
module mem_image_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_COUNT = 256,
  parameter int BASE_WORD  = 0,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mem_image_loader_if.master    bus,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [31:0]           checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_WORD);
  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH+1)'(WORD_COUNT);

  logic [1:0]            state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           pack_q, pack_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [31:0]           csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [1:0]            slot;
  logic [31:0]           word_next;
  logic [ADDR_WIDTH:0]   words_inc;

  // Byte position inside the word; big-endian simply mirrors the lane index.
  assign slot      = (BIG_ENDIAN != 0) ? ~lane_q : lane_q;
  assign words_inc = words_q + 1'b1;

  always_comb begin
    word_next = pack_q;
    case (slot)
      2'd0:    word_next[7:0]   = bus.byte_data;
      2'd1:    word_next[15:8]  = bus.byte_data;
      2'd2:    word_next[23:16] = bus.byte_data;
      default: word_next[31:24] = bus.byte_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pack_d  = pack_q;
    words_d = words_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RECV;
          lane_d  = 2'd0;
          pack_d  = '0;
          words_d = '0;
          csum_d  = '0;
        end
      end
      RECV: begin
        if (bus.byte_valid) begin
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Address and data are loaded here so they are already stable
            // on the registered outputs during the WRITE cycle.
            pack_d  = '0;
            wdata_d = word_next;
            addr_d  = BASE_ADDR + words_q[ADDR_WIDTH-1:0];
            state_d = WRITE;
          end else begin
            pack_d = word_next;
          end
        end
      end
      default: begin
        words_d = words_inc;
        csum_d  = csum_q + wdata_q;
        state_d = (words_inc == LAST_CNT) ? DONE : RECV;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      pack_q  <= '0;
      words_q <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      words_q <= words_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.byte_ready = (state_q == RECV);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign cpu_rst_n      = (state_q == DONE);
  assign busy           = (state_q == RECV) || (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign words_written  = words_q;
  assign checksum       = csum_q;

endmodule

// File: tb/tb_mem_image_loader.sv
module tb_mem_image_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_data;
  logic       byte_valid;

  always #5 clk = ~clk;

  mem_image_loader_if #(.ADDR_WIDTH(10)) if_le ();
  mem_image_loader_if #(.ADDR_WIDTH(10)) if_be ();
  mem_image_loader_if #(.ADDR_WIDTH(10)) if_wr ();

  assign if_le.byte_data  = byte_data;
  assign if_le.byte_valid = byte_valid;
  assign if_be.byte_data  = byte_data;
  assign if_be.byte_valid = byte_valid;
  assign if_wr.byte_data  = byte_data;
  assign if_wr.byte_valid = byte_valid;

  logic        le_cpu, le_busy, le_done;
  logic [10:0] le_ww;
  logic [31:0] le_cs;
  logic        be_cpu, be_busy, be_done;
  logic [10:0] be_ww;
  logic [31:0] be_cs;
  logic        wr_cpu, wr_busy, wr_done;
  logic [10:0] wr_ww;
  logic [31:0] wr_cs;

  mem_image_loader #(.ADDR_WIDTH(10), .WORD_COUNT(2), .BASE_WORD(0), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_le),
    .cpu_rst_n(le_cpu), .busy(le_busy), .done(le_done),
    .words_written(le_ww), .checksum(le_cs));

  mem_image_loader #(.ADDR_WIDTH(10), .WORD_COUNT(2), .BASE_WORD(0), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_be),
    .cpu_rst_n(be_cpu), .busy(be_busy), .done(be_done),
    .words_written(be_ww), .checksum(be_cs));

  mem_image_loader #(.ADDR_WIDTH(10), .WORD_COUNT(4), .BASE_WORD(1022), .BIG_ENDIAN(0)) u_wr (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if_wr),
    .cpu_rst_n(wr_cpu), .busy(wr_busy), .done(wr_done),
    .words_written(wr_ww), .checksum(wr_cs));

  // Write logs, captured mid-cycle.
  logic [41:0] le_log[$];
  logic [41:0] be_log[$];
  logic [41:0] wr_log[$];

  always @(negedge clk) begin
    if (if_le.mem_we) le_log.push_back({if_le.mem_addr, if_le.mem_wdata});
    if (if_be.mem_we) be_log.push_back({if_be.mem_addr, if_be.mem_wdata});
    if (if_wr.mem_we) wr_log.push_back({if_wr.mem_addr, if_wr.mem_wdata});
  end

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        cpu;
    logic [10:0] ww;
    logic [31:0] cs;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic rdy, logic we,
                              logic [9:0] addr, logic [31:0] wd, logic busy, logic done,
                              logic cpu, logic [10:0] ww, logic [31:0] cs);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd;
    r.busy = busy; r.done = done; r.cpu = cpu; r.ww = ww; r.cs = cs;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_le(input string tag, input int row, input vec_t e);
    chk({tag, " byte_ready"}, row, 32'(if_le.byte_ready), 32'(e.rdy));
    chk({tag, " mem_we"},     row, 32'(if_le.mem_we),     32'(e.we));
    chk({tag, " mem_addr"},   row, 32'(if_le.mem_addr),   32'(e.addr));
    chk({tag, " mem_wdata"},  row, if_le.mem_wdata,       e.wd);
    chk({tag, " busy"},       row, 32'(le_busy),          32'(e.busy));
    chk({tag, " done"},       row, 32'(le_done),          32'(e.done));
    chk({tag, " cpu_rst_n"},  row, 32'(le_cpu),           32'(e.cpu));
    chk({tag, " words"},      row, 32'(le_ww),            32'(e.ww));
    chk({tag, " checksum"},   row, le_cs,                 e.cs);
  endtask

  task automatic step(input logic st, input logic v, input logic [7:0] d);
    start      = st;
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    #1;
  endtask

  vec_t rst_v;
  int   we_before;

  initial begin
    rst_v = mk(0, 0, 8'h00, 0, 0, 10'd0, 32'h0, 0, 0, 0, 11'd0, 32'h0);

    // Inputs applied before an edge; expectations hold just after it.
    //             st v  d      rdy we addr   wdata         busy done cpu ww     checksum
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 10'd0, 32'h00000000, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h78, 1, 0, 10'd0, 32'h00000000, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h56, 1, 0, 10'd0, 32'h00000000, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h34, 1, 0, 10'd0, 32'h00000000, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h12, 0, 1, 10'd0, 32'h12345678, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'hEF, 1, 0, 10'd0, 32'h12345678, 1, 0, 0, 11'd1, 32'h12345678));
    tbl.push_back(mk(0, 1, 8'hEF, 1, 0, 10'd0, 32'h12345678, 1, 0, 0, 11'd1, 32'h12345678));
    tbl.push_back(mk(0, 1, 8'hBE, 1, 0, 10'd0, 32'h12345678, 1, 0, 0, 11'd1, 32'h12345678));
    tbl.push_back(mk(0, 1, 8'hAD, 1, 0, 10'd0, 32'h12345678, 1, 0, 0, 11'd1, 32'h12345678));
    tbl.push_back(mk(0, 1, 8'hDE, 0, 1, 10'd1, 32'hDEADBEEF, 1, 0, 0, 11'd1, 32'h12345678));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 10'd1, 32'hDEADBEEF, 0, 1, 1, 11'd2, 32'hF0E21567));
    // Reload from DONE, with a start pulse in RECV and one in WRITE.
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 10'd1, 32'hDEADBEEF, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h11, 1, 0, 10'd1, 32'hDEADBEEF, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(1, 1, 8'h22, 1, 0, 10'd1, 32'hDEADBEEF, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 10'd1, 32'hDEADBEEF, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h33, 1, 0, 10'd1, 32'hDEADBEEF, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(0, 1, 8'h44, 0, 1, 10'd0, 32'h44332211, 1, 0, 0, 11'd0, 32'h00000000));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 10'd0, 32'h44332211, 1, 0, 0, 11'd1, 32'h44332211));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 0, 10'd0, 32'h44332211, 1, 0, 0, 11'd1, 32'h44332211));
    tbl.push_back(mk(0, 1, 8'hBB, 1, 0, 10'd0, 32'h44332211, 1, 0, 0, 11'd1, 32'h44332211));
    tbl.push_back(mk(0, 1, 8'hCC, 1, 0, 10'd0, 32'h44332211, 1, 0, 0, 11'd1, 32'h44332211));
    tbl.push_back(mk(0, 1, 8'hDD, 0, 1, 10'd1, 32'hDDCCBBAA, 1, 0, 0, 11'd1, 32'h44332211));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 10'd1, 32'hDDCCBBAA, 0, 1, 1, 11'd2, 32'h21FFDDBB));
    tbl.push_back(mk(0, 1, 8'h99, 0, 0, 10'd1, 32'hDDCCBBAA, 0, 1, 1, 11'd2, 32'h21FFDDBB));

    rst_n = 1'b0;
    step(1, 1, 8'h5A);
    step(0, 0, 8'h00);
    chk_le("reset", -1, rst_v);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].v, tbl[i].d);
      chk_le("table", i, tbl[i]);
      if (i == 10) chk("be we count first load", i, 32'(be_log.size()), 32'd2);
    end

    // Big-endian packing, two loads of two words.
    chk("be write count", 0, 32'(be_log.size()), 32'd4);
    if (be_log.size() == 4) begin
      chk("be write0", 0, 32'(be_log[0][41:32]), 32'd0);
      chk("be data0",  0, be_log[0][31:0], 32'h78563412);
      chk("be write1", 1, 32'(be_log[1][41:32]), 32'd1);
      chk("be data1",  1, be_log[1][31:0], 32'hEFBEADDE);
      chk("be data2",  2, be_log[2][31:0], 32'h11223344);
      chk("be data3",  3, be_log[3][31:0], 32'hAABBCCDD);
    end
    chk("be checksum", 0, be_cs, 32'h11223344 + 32'hAABBCCDD);

    // Address wrap from base 1022 over a four-word image.
    chk("wrap write count", 0, 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      chk("wrap addr0", 0, 32'(wr_log[0][41:32]), 32'd1022);
      chk("wrap addr1", 1, 32'(wr_log[1][41:32]), 32'd1023);
      chk("wrap addr2", 2, 32'(wr_log[2][41:32]), 32'd0);
      chk("wrap addr3", 3, 32'(wr_log[3][41:32]), 32'd1);
      chk("wrap data2", 2, wr_log[2][31:0], 32'h44332211);
    end
    chk("wrap words", 0, 32'(wr_ww), 32'd4);
    chk("wrap checksum", 0, wr_cs, 32'h12E1F322);
    chk("wrap done", 0, 32'(wr_done), 32'd1);
    chk("wrap cpu_rst_n", 0, 32'(wr_cpu), 32'd1);
    chk("le write count", 0, 32'(le_log.size()), 32'd4);

    // Reset after six bytes of a load: first word written, bytes 5-6 dropped.
    we_before = le_log.size();
    step(1, 0, 8'h00);
    step(0, 1, 8'h01);
    step(0, 1, 8'h02);
    step(0, 1, 8'h03);
    step(0, 1, 8'h04);
    chk("abort first word", 0, if_le.mem_wdata, 32'h04030201);
    step(0, 0, 8'h00);
    step(0, 1, 8'h05);
    step(0, 1, 8'h06);
    rst_n = 1'b0;
    step(0, 1, 8'h07);
    chk_le("abort reset", 0, rst_v);
    step(0, 0, 8'h00);
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    chk("abort write count", 0, 32'(le_log.size() - we_before), 32'd1);
    chk_le("abort idle", 1, rst_v);

    step(1, 0, 8'h00);
    step(0, 1, 8'hA1);
    step(0, 1, 8'hA2);
    step(0, 1, 8'hA3);
    step(0, 1, 8'hA4);
    chk_le("reload", 0, mk(0, 0, 8'h00, 0, 1, 10'd0, 32'hA4A3A2A1, 1, 0, 0, 11'd0, 32'h0));
    step(0, 0, 8'h00);
    chk_le("reload", 1, mk(0, 0, 8'h00, 1, 0, 10'd0, 32'hA4A3A2A1, 1, 0, 0, 11'd1, 32'hA4A3A2A1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
- Writer side of the data-memory image path: accepts a byte stream over a valid/ready handshake, packs it into 32-bit words and writes them sequentially into CPU RAM starting at a configurable word base.
- Holds the multicycle CPU in reset until the image is fully written, then releases it, so a run starts from a known memory image that the end-of-run memory compare checks against.
- Reports a running 32-bit word checksum and a word count for cross-checking against the image file.

Parameters:
ADDR_WIDTH, 10, word-address width of the RAM write port
WORD_COUNT, 256, number of 32-bit words per image (1..2^ADDR_WIDTH)
BASE_WORD, 0, first word address written
BIG_ENDIAN, 0, 0: first byte received -> bits [7:0]; 1: first byte received -> bits [31:24]

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins a load (honoured in IDLE and DONE only)
byte_data  in  8  stream byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  loader can accept a byte this cycle
mem_we  out  1  RAM write enable, one cycle per word
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  32  RAM write data
cpu_rst_n  out  1  CPU reset, low while loading
busy  out  1  high in RECV or WRITE
done  out  1  high in DONE
words_written  out  ADDR_WIDTH+1  words committed this load
checksum  out  32  sum mod 2^32 of words committed this load

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, words_written=0, checksum=0; lane counter=0, pack register=0. Reset mid-load aborts immediately; partially packed word discarded, no write issued.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: cpu_rst_n=0. start -> RECV; clear lane, words_written, checksum.
- RECV: byte_ready=1 (combinational from state). Transfer occurs when byte_valid && byte_ready at edge. Byte placed in lane per BIG_ENDIAN; lane increments. Transfer on lane 3 -> WRITE next cycle, lane wraps to 0. byte_valid without transfer impossible in RECV; byte_valid ignored in all other states (byte_ready=0). byte_data may change freely when byte_valid=0.
- WRITE (exactly one cycle): mem_we=1, mem_addr=BASE_WORD+words_written (truncated to ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH), mem_wdata=packed word. At edge: words_written+1, checksum+=word. If new words_written==WORD_COUNT -> DONE, else RECV. Latency: 4th accepted byte -> write strobe next cycle; per-word throughput 5 cycles min.
- mem_addr/mem_wdata outputs are registered and hold last value outside WRITE; mem_we=0 outside WRITE.
- DONE: done=1, cpu_rst_n=1, busy=0; words_written and checksum held. start in DONE -> RECV, counters cleared, cpu_rst_n drops to 0 in same cycle state leaves DONE (reload).
- start in RECV/WRITE ignored (no restart, no counter clear).
- cpu_rst_n=1 only in DONE; never glitches high during load.

Test Plan:
- Reset then start, BIG_ENDIAN=0, bytes 78 56 34 12 EF BE AD DE with valid always high, WORD_COUNT=2 -> writes 0x12345678 @0 then 0xDEADBEEF @1, checksum=0xF0E21567, words_written=2, done=1, cpu_rst_n=1.
- Same stream with BIG_ENDIAN=1 -> writes 0x78563412 and 0xEFBEADDE; mem_we asserted exactly 2 cycles total.
- Random byte_valid gaps (50% duty) on 256-word image from file -> RAM contents match file word-for-word, one mem_we per 4 accepted bytes, cpu_rst_n low until final write edge+1.
- BASE_WORD=1022, ADDR_WIDTH=10, WORD_COUNT=4 -> addresses 1022, 1023, 0, 1 (wrap).
- rst_n low after 6 bytes of a load -> no write for bytes 5-6, all outputs at reset values next cycle; new start loads cleanly from lane 0.
- start pulsed during RECV -> ignored, counters intact; start in DONE -> cpu_rst_n=0, counters cleared, second image loads correctly.
